// File: rtl/max_pkg.sv
// Shared definitions for the streaming max finder: frame states and compare modes.
package max_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam bit CMP_SIGNED   = 1'b1;
    localparam bit CMP_UNSIGNED = 1'b0;

endpackage

// File: rtl/stream_max_finder_if.sv
// Sample-in / result-out valid-ready bundle for the streaming max finder.
interface stream_max_finder_if #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_max;
    logic [IDX_W-1:0]  m_idx;
    logic [CNT_W-1:0]  m_count;
    logic              m_by_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_max, m_idx, m_count, m_by_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_max, m_idx, m_count, m_by_last
    );
endinterface

// File: rtl/max_cmp.sv
// Single full-width magnitude comparator: a_gt_b = (a > b) in the selected number format.
module max_cmp
    import max_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter bit SIGNED = CMP_SIGNED
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              a_gt_b
);

    generate
        if (SIGNED == CMP_SIGNED) begin : g_signed
            assign a_gt_b = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign a_gt_b = a > b;
        end
    endgenerate

endmodule

// File: rtl/stream_max_finder.sv
// Streaming max-of-N reduction: tracks running max/first index/count per frame and
// presents one result beat per frame on a valid/ready output.
module stream_max_finder
    import max_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 4,
    parameter bit SIGNED = CMP_SIGNED
) (
    input logic               clk,
    input logic               rst,
    stream_max_finder_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] max_reg,   max_next;
    logic [IDX_W-1:0]  idx_reg,   idx_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;

    // Result registers are separate from the running registers so a new frame can
    // start accumulating while the last result stays visible on the outputs.
    logic [DATA_W-1:0] res_max_reg,  res_max_next;
    logic [IDX_W-1:0]  res_idx_reg,  res_idx_next;
    logic [CNT_W-1:0]  res_cnt_reg,  res_cnt_next;
    logic              res_last_reg, res_last_next;

    logic accept;
    logic close;
    logic a_gt_b;

    max_cmp #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a      (bus.s_data),
        .b      (max_reg),
        .a_gt_b (a_gt_b)
    );

    assign bus.s_ready   = (state_reg != HOLD) && !rst;
    assign bus.m_valid   = (state_reg == HOLD);
    assign bus.m_max     = res_max_reg;
    assign bus.m_idx     = res_idx_reg;
    assign bus.m_count   = res_cnt_reg;
    assign bus.m_by_last = res_last_reg;

    assign accept = bus.s_valid && bus.s_ready;

    always_comb begin
        state_next    = state_reg;
        max_next      = max_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        res_max_next  = res_max_reg;
        res_idx_next  = res_idx_reg;
        res_cnt_next  = res_cnt_reg;
        res_last_next = res_last_reg;
        close         = 1'b0;

        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    max_next   = bus.s_data;
                    idx_next   = '0;
                    cnt_next   = ONE_C;
                    close      = bus.s_last || (ONE_C == DEPTH_C);
                    state_next = close ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    cnt_next = cnt_reg + ONE_C;
                    // Strictly greater only, so ties keep the earliest index.
                    if (a_gt_b) begin
                        max_next = bus.s_data;
                        idx_next = IDX_W'(cnt_reg);
                    end
                    close      = bus.s_last || (cnt_next == DEPTH_C);
                    state_next = close ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        if (close) begin
            res_max_next  = max_next;
            res_idx_next  = idx_next;
            res_cnt_next  = cnt_next;
            res_last_next = bus.s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            max_reg      <= '0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            res_max_reg  <= '0;
            res_idx_reg  <= '0;
            res_cnt_reg  <= '0;
            res_last_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            max_reg      <= max_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            res_max_reg  <= res_max_next;
            res_idx_reg  <= res_idx_next;
            res_cnt_reg  <= res_cnt_next;
            res_last_reg <= res_last_next;
        end
    end

endmodule

// File: doc/stream_max_finder.md
# stream_max_finder

Streaming max-of-N reduction block. It accepts a framed sample stream over a valid/ready handshake and finds the maximum sample and its position with a single comparator. It then presents the maximum, index and sample count as one result beat on a valid/ready output. This is the parametrised successor to the team's fixed 4-entry, 9-bit max finders. It sits between a sample producer (ADC/filter stage) and downstream peak-detect or AGC logic.

## Interface
- DATA_W, 9: sample width in bits.
- DEPTH, 4: maximum samples per frame (≥2). Derived localparams: IDX_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).
- SIGNED, 1: 1 = two's-complement compare; 0 = unsigned compare.
- clk  in  1  the single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_W  sample.
- s_last  in  1  sample closes the frame.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_max  out  DATA_W  maximum sample of the frame.
- m_idx  out  IDX_W  position (0-based) of the first occurrence of the maximum.
- m_count  out  CNT_W  samples in the frame (1..DEPTH).
- m_by_last  out  1  1 = frame closed by s_last; 0 = closed by reaching DEPTH.

## Operation
- Handshakes: input beat accepted when s_valid && s_ready. Output beat completes when m_valid && m_ready.
- States: EMPTY (no samples in frame), ACC (≥1 sample held), HOLD (result presented).
- EMPTY: s_ready=1. An accepted sample loads max=s_data, idx=0, cnt=1 unconditionally.
- ACC: s_ready=1. An accepted sample is compared against the running max. Strictly greater replaces max and sets idx=cnt. Equal or less keeps the current max, so ties keep the earliest index. cnt increments.
- Frame closes on the accepted sample where s_last=1 or the new cnt==DEPTH. That sample is included in the result. m_by_last=s_last of that sample, and the state goes to HOLD.
- A single-sample frame (s_last on the first beat) goes EMPTY→HOLD with count 1.
- HOLD: s_ready=0, m_valid=1. m_max, m_idx, m_count and m_by_last are stable until the output handshake completes, then the state returns to EMPTY.
- Samples following a DEPTH closure without s_last start a new frame. No data is dropped.
- Compare: $signed when SIGNED=1, $unsigned otherwise. No arithmetic widening is needed; the compare is full DATA_W.

## Timing
- Reset, while rst=1 and in the first cycle after: state EMPTY, m_valid=0, m_max=0, m_idx=0, m_count=0, m_by_last=0.
- s_ready is combinational from state. It is 0 while rst=1 and 1 in the first cycle after reset deassertion.
- Latency: the closing sample is accepted at edge t, and m_valid=1 in the cycle after t.
- Throughput: one sample per cycle within a frame. There is one dead input cycle per frame (HOLD), or more under backpressure.
- Output handshake at edge u: s_ready=1 in the cycle after u. s_valid asserted during HOLD is ignored, and s_data need not be stable.
- Result outputs keep their last values after the handshake until the next frame closes. Only m_valid drops.
- Reset mid-frame or in HOLD: the partial frame or pending result is discarded. All outputs take their reset values at the next edge.
- No combinational path from m_ready to s_ready.

## Structure
- Shared package max_pkg: state encoding (EMPTY/ACC/HOLD) and cmp-mode constants (CMP_SIGNED/CMP_UNSIGNED).
- Sub-module max_cmp: combinational comparator, parameters DATA_W and SIGNED, output a_gt_b. It is instantiated once; the block uses exactly one comparator.
- Top holds the state machine, running max/idx/cnt registers, and output registers.

## Test plan
- DATA_W=9, DEPTH=4, SIGNED=1, m_ready=1. Frame {5, -3, 200, 7}, s_last on the 4th sample → m_max=200, m_idx=2, m_count=4, m_by_last=1; m_valid one cycle after the last accept.
- Frame {9'h1FF, 9'h001} with last: SIGNED=1 → m_max=1, m_idx=1. SIGNED=0 → m_max=511, m_idx=0.
- Ties {7, 7, 3}, last on the 3rd → m_max=7, m_idx=0, m_count=3. Single sample {-5} with last → m_max=-5, m_idx=0, m_count=1.
- Six samples {1,2,3,4,9,8}, last only on the 6th:
  - frame 1 → m_max=4, m_idx=3, m_count=4, m_by_last=0;
  - frame 2 → m_max=9, m_idx=0, m_count=2, m_by_last=1.
- Backpressure: hold m_ready=0 for 5 cycles in HOLD while s_valid=1 → outputs stable, s_ready=0, no samples accepted. After the handshake, s_ready=1 the next cycle.
- Pulse rst after 2 samples {50, 60} → all outputs at reset values. Next frame {3}, last → m_max=3, m_count=1, with no carry-over.
